// File: rtl/data_ram.sv
// Synchronous data memory for the 5-stage core: byte-strobed stores and
// one-cycle loads returned byte-selected and extended, plus an access fault flag.
//
// state | meaning
// IDLE  | no load response on the l3 outputs this cycle
// RESP  | load response valid on ram_rdata_l3 / ram_valid_l3
module data_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ram_en_l2,
  input  logic        ram_we_l2,
  input  logic [31:0] ram_addr_l2,
  input  logic [31:0] ram_wdata_l2,
  input  logic [2:0]  ram_funct3_l2,
  output logic [31:0] ram_rdata_l3,
  output logic        ram_valid_l3,
  output logic        ram_fault_l3
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [1:0]        size;
  logic              misaligned;
  logic              illegal;
  logic              fault;
  logic              st_ok;
  logic              ld_ok;
  logic [3:0]        strb;
  logic [31:0]       wrep;
  logic [31:0]       word_q;
  logic [1:0]        lane_q;
  logic [2:0]        f3_q;
  logic              fault_q;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       ext;
  logic              unused_addr_bits;

  assign idx  = ram_addr_l2[IDX_W+1:2];
  assign lane = ram_addr_l2[1:0];
  assign size = ram_funct3_l2[1:0];
  assign unused_addr_bits = ^ram_addr_l2[31:IDX_W+2];

  assign misaligned = ((size == 2'd1) && lane[0]) || ((size == 2'd2) && (lane != 2'd0));
  assign illegal    = ram_we_l2 ? (ram_funct3_l2 > 3'd2)
                                : ((ram_funct3_l2 == 3'd3) || (ram_funct3_l2[2:1] == 2'b11));
  assign fault      = ram_en_l2 & (misaligned | illegal);
  // rstn gates writes so nothing lands in the array while reset is held
  assign st_ok      = rstn & ram_en_l2 & ram_we_l2 & ~fault;
  assign ld_ok      = ram_en_l2 & ~ram_we_l2 & ~fault;

  always_comb begin
    strb = 4'b1111;
    wrep = ram_wdata_l2;
    case (size)
      2'd0: begin
        strb = 4'b0001 << lane;
        wrep = {4{ram_wdata_l2[7:0]}};
      end
      2'd1: begin
        strb = 4'b0011 << lane;
        wrep = {2{ram_wdata_l2[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (st_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      word_q  <= '0;
      lane_q  <= '0;
      f3_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault;
      if (ld_ok) begin
        word_q <= mem[idx];
        lane_q <= lane;
        f3_q   <= ram_funct3_l2;
      end
    end
  end

  always_comb begin
    state_d      = IDLE;
    ram_valid_l3 = 1'b0;
    ram_rdata_l3 = '0;
    byte_sel     = word_q[{lane_q, 3'b000} +: 8];
    half_sel     = lane_q[1] ? word_q[31:16] : word_q[15:0];
    case (f3_q[1:0])
      2'd0:    ext = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'd1:    ext = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: ext = word_q;
    endcase
    if (ld_ok) state_d = RESP;
    if (state_q == RESP) begin
      ram_valid_l3 = 1'b1;
      ram_rdata_l3 = ext;
    end
  end

  assign ram_fault_l3 = fault_q;

endmodule

// File: tb/tb_data_ram.sv
// Randomised self-checking bench for data_ram: byte-addressed reference memory,
// per-cycle output compare, and literal checks from the directed scenarios.
module tb_data_ram;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] MASK  = 32'(DEPTH * 4 - 1);

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  f3 = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        fault;

  logic [7:0]  mdl [DEPTH*4];
  logic [31:0] exp_rdata = '0;
  logic        exp_valid = 1'b0;
  logic        exp_fault = 1'b0;
  logic        chk_on = 1'b0;
  int          errors = 0;
  int          checks = 0;

  data_ram #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .ram_en_l2(en), .ram_we_l2(we), .ram_addr_l2(addr),
    .ram_wdata_l2(wdata), .ram_funct3_l2(f3),
    .ram_rdata_l3(rdata), .ram_valid_l3(valid), .ram_fault_l3(fault)
  );

  always #5 clk = ~clk;

  function automatic bit is_fault(logic w, logic [31:0] a, logic [2:0] f);
    bit legal;
    int sz;
    legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz = 1 << f[1:0];
    return !legal || ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] a, logic [2:0] f);
    logic [31:0] v;
    int n;
    n = 1 << f[1:0];
    v = '0;
    for (int k = 0; k < n; k++)
      v = v | (32'(mdl[int'((a + 32'(k)) & MASK)]) << (8 * k));
    if (!f[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Reference: memory is a flat byte array, requests applied at the clock edge
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_rdata <= '0;
      exp_valid <= 1'b0;
      exp_fault <= 1'b0;
    end else begin
      exp_rdata <= '0;
      exp_valid <= 1'b0;
      exp_fault <= 1'b0;
      if (en) begin
        if (is_fault(we, addr, f3)) exp_fault <= 1'b1;
        else if (we) begin
          for (int k = 0; k < (1 << f3[1:0]); k++)
            mdl[int'((addr + 32'(k)) & MASK)] <= wdata[8*k +: 8];
        end else begin
          exp_valid <= 1'b1;
          exp_rdata <= load_val(addr, f3);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks += 3;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL cyc_rdata t=%0t got=%h want=%h", $time, rdata, exp_rdata);
      end
      if (valid !== exp_valid) begin
        errors++;
        $display("FAIL cyc_valid t=%0t got=%b want=%b", $time, valid, exp_valid);
      end
      if (fault !== exp_fault) begin
        errors++;
        $display("FAIL cyc_fault t=%0t got=%b want=%b", $time, fault, exp_fault);
      end
    end
  end

  task automatic req(input logic e, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    en = e; we = w; addr = a; wdata = d; f3 = f;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Checks the response to the request issued just before, against literals
  task automatic lit(input string name, input logic [31:0] r, input logic v, input logic flt);
    @(posedge clk);
    #1;
    check({name, "_rdata"}, rdata, r);
    check({name, "_valid"}, 32'(valid), 32'(v));
    check({name, "_fault"}, 32'(fault), 32'(flt));
    check({name, "_model"}, exp_rdata, r);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b1;

    for (int i = 0; i < DEPTH; i++) req(1'b1, 1'b1, 32'(i * 4), $urandom, 3'd2);

    req(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2);
    req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);        lit("lw_first", 32'hDEAD_BEEF, 1'b1, 1'b0);
    req(1'b1, 1'b1, 32'h11, 32'h0000_007F, 3'd0);
    req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);        lit("lw_after_sb", 32'hDEAD_7FEF, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h13, 32'h0, 3'd0);        lit("lb", 32'hFFFF_FFDE, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h13, 32'h0, 3'd4);        lit("lbu", 32'h0000_00DE, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h12, 32'h0, 3'd1);        lit("lh", 32'hFFFF_DEAD, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h12, 32'h0, 3'd5);        lit("lhu", 32'h0000_DEAD, 1'b1, 1'b0);
    req(1'b1, 1'b1, 32'h13, 32'h0000_1234, 3'd1); lit("sh_misal", 32'h0, 1'b0, 1'b1);
    req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);        lit("lw_no_write", 32'hDEAD_7FEF, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h02, 32'h0, 3'd2);        lit("lw_misal", 32'h0, 1'b0, 1'b1);
    req(1'b1, 1'b0, 32'h00, 32'h0, 3'd3);        lit("ld_f3_3", 32'h0, 1'b0, 1'b1);
    req(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 3'd4); lit("st_f3_4", 32'h0, 1'b0, 1'b1);
    req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);        lit("lw_after_bad", 32'hDEAD_7FEF, 1'b1, 1'b0);
    req(1'b1, 1'b1, 32'h1000, 32'hA5A5_A5A5, 3'd2);
    req(1'b1, 1'b0, 32'h0000, 32'h0, 3'd2);      lit("wrap", 32'hA5A5_A5A5, 1'b1, 1'b0);
    idle();                                       lit("idle", 32'h0, 1'b0, 1'b0);

    req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(valid), 32'h1);
    rstn = 1'b0;
    #1;
    check("async_rdata", rdata, 32'h0);
    check("async_valid", 32'(valid), 32'h0);
    check("async_fault", 32'(fault), 32'h0);
    idle();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle();
    req(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);        lit("retained", 32'hDEAD_7FEF, 1'b1, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] a;
      logic [2:0]  f;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(1 << f[1:0]) - 32'd1);
      req(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), a, $urandom, f);
    end
    idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Synchronous data-memory responder for the 5-stage core.
- Accepts one load or store request per cycle from the memory-access stage (l2-side signals).
- Returns load data, already byte-selected and sign/zero-extended, one cycle later as ram_rdata_l3. This is the value the register file writes back when load_l3 is set.
- Also flags misaligned or illegal accesses so the pipeline can trap.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two ≥ 4.
- IDX_W, $clog2(DEPTH_WORDS), word-index width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- ram_en_l2  input  1  request valid this cycle
- ram_we_l2  input  1  1 = store, 0 = load; ignored when ram_en_l2 = 0
- ram_addr_l2  input  32  byte address
- ram_wdata_l2  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
- ram_funct3_l2  input  3  RV32I funct3: load 0=LB 1=LH 2=LW 4=LBU 5=LHU; store 0=SB 1=SH 2=SW
- ram_rdata_l3  output  32  extended load result
- ram_valid_l3  output  1  high one cycle after an accepted load
- ram_fault_l3  output  1  high one cycle after a misaligned or illegal request

Behaviour:
- Reset (rstn low, asynchronous):
  - ram_rdata_l3, ram_valid_l3 and ram_fault_l3 go to 0 immediately.
  - The array contents are NOT cleared.
  - A request presented on the edge where rstn deasserts is ignored.
- Word index = ram_addr_l2[IDX_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Legality check, combinational on l2 inputs:
  - Misaligned if (funct3[1:0] = 1 and addr[0] = 1) or (funct3[1:0] = 2 and addr[1:0] ≠ 0).
  - Illegal if load funct3 ∈ {3, 6, 7} or store funct3 ∉ {0, 1, 2}.
  - fault = ram_en_l2 & (misaligned | illegal).
- Store, accepted when en & we & !fault:
  - Byte strobes are built from funct3 and addr[1:0]:
    - SB: 1 << addr[1:0]
    - SH: 4'b0011 << addr[1:0]
    - SW: 4'b1111
  - Write data is replicated to every lane: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}.
  - Only strobed bytes are written at the posedge.
  - Next cycle: ram_valid_l3 = 0 and ram_rdata_l3 = 0.
- Load, accepted when en & !we & !fault:
  - The word is read at the posedge.
  - ram_addr_l2[1:0] and funct3 are registered alongside it.
  - The l3 output is formed from the registered lane:
    - LB/LBU: byte addr[1:0], sign- or zero-extended.
    - LH/LHU: half addr[1], sign- or zero-extended.
    - LW: full word.
  - ram_valid_l3 = 1 for exactly one cycle.
  - Latency: exactly 1 cycle, no stall, no backpressure.
- Fault:
  - No array write.
  - Next cycle ram_fault_l3 = 1, ram_valid_l3 = 0, ram_rdata_l3 = 0.
- Idle (ram_en_l2 = 0): next cycle all three outputs are 0.
- Back-to-back: store to word W at cycle n, then load from W at cycle n+1, returns the new bytes. This follows naturally from write-at-edge / read-at-next-edge.
- One request per cycle, so there is no same-cycle read/write collision.
- Outputs are registered; none depend combinationally on l2 inputs.
- State per cycle: l3 output registers {rdata word, addr[1:0], funct3, valid, fault} plus the array. These form a 2-state pipeline stage (IDLE / RESP).

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> next cycle ram_rdata_l3 = 0xDEADBEEF, ram_valid_l3 = 1, ram_fault_l3 = 0.
- Following that, SB 0x7F @0x11 then LW @0x10 -> 0xDEAD7FEF. Then LB @0x13 -> 0xFFFFFFDE, LBU @0x13 -> 0x000000DE, LH @0x12 -> 0xFFFFDEAD, LHU @0x12 -> 0x0000DEAD.
- SH 0x1234 @0x13 (misaligned) -> ram_fault_l3 = 1, rdata = 0, valid = 0. A subsequent LW @0x10 still returns 0xDEAD7FEF (no write occurred). LW @0x2 -> fault = 1.
- Load with funct3 = 3 @0x0 -> fault = 1. Store with funct3 = 4 -> fault = 1 and memory unchanged.
- Wrap: DEPTH_WORDS = 1024, SW 0xA5A5A5A5 @0x1000, then LW @0x0000 -> 0xA5A5A5A5.
- Assert rstn low mid-cycle while ram_valid_l3 = 1 -> outputs drop to 0 without waiting for clk. After release, LW @0x10 -> 0xDEAD7FEF (contents retained).
